// File: rtl/write_back_buffer_pkg.sv
// Shared CPU parameters for the D-cache write-back path.
package write_back_buffer_pkg;
    localparam int WORD             = 32;
    localparam int LINE_WORDS_DEF   = 4;
    localparam int CACHE_LINE_WIDTH = WORD * LINE_WORDS_DEF;
    localparam int ADDR_W_DEF       = 32;
    localparam int OFS_W_DEF        = $clog2(CACHE_LINE_WIDTH / 8);
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
endpackage

// File: rtl/write_back_buffer.sv
// Single-entry write-back buffer: captures one evicted line and replays it
// as an AXI INCR burst (AW, then W beats, then B), with a line-address hazard check.
module write_back_buffer
    import write_back_buffer_pkg::*;
#(
    parameter int WORD_W     = WORD,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [WORD_W*LINE_WORDS-1:0] in_line,
    output logic                       ready,
    output logic                       awvalid,
    output logic [ADDR_W-1:0]          awaddr,
    output logic [7:0]                 awlen,
    input  logic                       awready,
    output logic                       wvalid,
    output logic [WORD_W-1:0]          wdata,
    output logic [WORD_W/8-1:0]        wstrb,
    output logic                       wlast,
    input  logic                       wready,
    input  logic                       bvalid,
    output logic                       bready,
    input  logic [ADDR_W-1:0]          chk_addr,
    output logic                       chk_hit
);
    localparam int LINE_W = WORD_W * LINE_WORDS;
    localparam int OFS_W  = $clog2(LINE_WORDS * WORD_W / 8);
    localparam int CNT_W  = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] HI_MASK  = ~((ADDR_W'(1) << OFS_W) - ADDR_W'(1));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            line_q <= '0;
        end else begin
            state <= state_nxt;
            // Capture only when empty; a we while busy never touches the held line.
            if (state == S_IDLE && we) begin
                addr_q <= in_addr;
                line_q <= in_line;
                cnt    <= '0;
            end else if (state == S_W && wready) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (we)                       state_nxt = S_AW;
            S_AW:   if (awready)                  state_nxt = S_W;
            S_W:    if (wready && cnt == CNT_LAST) state_nxt = S_B;
            S_B:    if (bvalid)                   state_nxt = S_IDLE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready   = (state == S_IDLE);
        awvalid = (state == S_AW);
        wvalid  = (state == S_W);
        bready  = (state == S_B);
        wlast   = (state == S_W) && (cnt == CNT_LAST);
        awaddr  = addr_q & HI_MASK;
        awlen   = 8'(LINE_WORDS - 1);
        wstrb   = '1;
        wdata   = line_q[cnt*WORD_W +: WORD_W];
        // Offset bits are masked out so any byte inside the held line matches.
        chk_hit = (state != S_IDLE) && (((chk_addr ^ addr_q) & HI_MASK) == '0);
    end
endmodule

// File: tb/tb_write_back_buffer.sv
// Directed self-checking bench for write_back_buffer (default 4 x 32-bit line).
module tb_write_back_buffer;
    logic         clk = 0;
    logic         rst = 1;
    logic         we = 0;
    logic [31:0]  in_addr = 0;
    logic [127:0] in_line = 0;
    logic         ready, awvalid, wvalid, wlast, bready, chk_hit;
    logic [31:0]  awaddr, wdata;
    logic [7:0]   awlen;
    logic [3:0]   wstrb;
    logic         awready = 0, wready = 0, bvalid = 0;
    logic [31:0]  chk_addr = 0;

    int errors = 0;
    int checks = 0;

    write_back_buffer dut (
        .clk(clk), .rst(rst), .we(we), .in_addr(in_addr), .in_line(in_line),
        .ready(ready), .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen),
        .awready(awready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wready(wready), .bvalid(bvalid), .bready(bready),
        .chk_addr(chk_addr), .chk_hit(chk_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] l, input int i);
        return l[i*32 +: 32];
    endfunction

    // Called in the capture cycle with all handshakes high; checks a clean 6-cycle burst.
    task automatic expect_burst(input logic [127:0] l, input logic [31:0] exp_aw);
        cyc();
        we = 0;
        check("aw_valid", awvalid, 1);
        check("aw_addr", awaddr, exp_aw);
        check("aw_wvalid", wvalid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("w_valid", wvalid, 1);
            check("w_data", wdata, word_of(l, i));
            check("w_last", wlast, (i == 3));
        end
        cyc();
        check("b_ready", bready, 1);
        check("b_busy", ready, 0);
        cyc();
        check("ret_ready", ready, 1);
    endtask

    localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L2 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    localparam logic [127:0] L3 = 128'h0000000D_0000000C_0000000B_0000000A;
    localparam logic [127:0] L4 = 128'h87654321_76543210_65432101_54321012;
    localparam logic [127:0] L5 = 128'h5555AAAA_4444BBBB_3333CCCC_2222DDDD;
    localparam logic [127:0] L6 = 128'h01020304_05060708_090A0B0C_0D0E0F10;

    initial begin
        int beats;
        int budget;
        logic [31:0] aw_hold;

        cyc(); cyc();
        rst = 0;
        // reset state
        check("rst_ready", ready, 1);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_bready", bready, 0);
        check("rst_chk_hit", chk_hit, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata", wdata, 0);

        // basic burst with hazard probes
        awready = 1; wready = 1; bvalid = 1;
        we = 1; in_addr = 32'h1C00_0014; in_line = L1;
        chk_addr = 32'h1C00_001C;
        #1 check("idle_chk_hit", chk_hit, 0);
        cyc();
        we = 0;
        check("b1_awvalid", awvalid, 1);
        check("b1_awaddr", awaddr, 32'h1C00_0010);
        check("b1_awlen", awlen, 3);
        check("b1_hit", chk_hit, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_addr = (i == 1) ? 32'h1C00_0020 : 32'h1C00_001C;
            #1;
            check("b1_wvalid", wvalid, 1);
            check("b1_wdata", wdata, word_of(L1, i));
            check("b1_wlast", wlast, (i == 3));
            check("b1_wstrb", wstrb, 4'hF);
            check("b1_hit", chk_hit, (i != 1));
        end
        cyc();
        check("b1_bready", bready, 1);
        check("b1_wvalid_b", wvalid, 0);
        cyc();
        check("b1_ready", ready, 1);
        check("b1_idle_hit", chk_hit, 0);

        // backpressure: awready low 3 cycles, wready 1,0,0,1,...
        awready = 0; wready = 0; bvalid = 0;
        we = 1; in_addr = 32'h2000_0048; in_line = L2;
        cyc();
        we = 0;
        for (int i = 0; i < 3; i++) begin
            check("bp_awvalid", awvalid, 1);
            check("bp_awaddr", awaddr, 32'h2000_0040);
            check("bp_wvalid", wvalid, 0);
            if (i == 2) awready = 1;
            cyc();
        end
        awready = 0;
        beats = 0;
        budget = 0;
        while (wvalid && budget < 40) begin
            wready = (budget % 3 == 0);
            check("bp_wdata", wdata, word_of(L2, beats));
            check("bp_wlast", wlast, (beats == 3));
            if (wready) beats++;
            budget++;
            cyc();
        end
        wready = 0;
        check("bp_beats", beats, 4);
        check("bp_bready", bready, 1);
        cyc();
        check("bp_bhold", bready, 1);
        bvalid = 1;
        cyc();
        check("bp_ready", ready, 1);

        // illegal overwrite while in W
        awready = 1; wready = 1;
        we = 1; in_addr = 32'h3000_0000; in_line = L3;
        cyc();
        check("ov_awaddr", awaddr, 32'h3000_0000);
        aw_hold = awaddr;
        for (int i = 0; i < 4; i++) begin
            cyc();
            we = 1; in_line = '1; in_addr = 32'h4000_0000;
            #1;
            check("ov_wdata", wdata, word_of(L3, i));
            check("ov_awaddr_hold", awaddr, aw_hold);
        end
        cyc();
        we = 0;
        check("ov_bready", bready, 1);
        cyc();
        check("ov_ready", ready, 1);

        // reset mid-burst, after beats 0 and 1 accepted
        we = 1; in_addr = 32'h5000_0030; in_line = L4;
        cyc(); we = 0;
        cyc(); check("mr_w0", wdata, word_of(L4, 0));
        cyc(); check("mr_w1", wdata, word_of(L4, 1));
        cyc(); check("mr_w2", wdata, word_of(L4, 2));
        rst = 1;
        cyc();
        rst = 0;
        chk_addr = 32'h5000_0030;
        #1;
        check("mr_wvalid", wvalid, 0);
        check("mr_ready", ready, 1);
        check("mr_hit", chk_hit, 0);
        check("mr_awvalid", awvalid, 0);
        we = 1; in_addr = 32'h6000_0050; in_line = L5;
        expect_burst(L5, 32'h6000_0050);

        // back-to-back: capture in the cycle ready returns
        we = 1; in_addr = 32'h7000_00F4; in_line = L6;
        expect_burst(L6, 32'h7000_00F0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
